// File: rtl/piso_serializer.sv
// Parallel-in serial-out driver for a downstream D latch: each bit gets a setup cycle then a strobe cycle.
// Optional even-parity slot after the data bits is compiled in with PISO_SERIALIZER_PARITY_EN.
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             C,
    input  logic             Rn,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] P,
    output logic             D,
    output logic             G,
    output logic             BUSY,
    output logic             DONE
);

    // state | meaning
    // IDLE  | waiting for LOAD, D holds last bit, G low
    // SHIFT | data bit slots, MSB first (setup cycle then strobe cycle)
    // PAR   | parity slot (PISO_SERIALIZER_PARITY_EN only)
    // FIN   | DONE pulse cycle, LOAD may start the next word here
`ifdef PISO_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2, FIN = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, FIN = 2'd3} state_t;
`endif

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             d_q, d_n;
    logic             g_q, g_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             accept;
`ifdef PISO_SERIALIZER_PARITY_EN
    logic             par_q, par_n;
`endif

    always_ff @(posedge C or negedge Rn) begin
        if (!Rn) begin
            state  <= IDLE;
            sreg   <= '0;
            cnt    <= '0;
            d_q    <= 1'b0;
            g_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
            par_q  <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            sreg   <= sreg_n;
            cnt    <= cnt_n;
            d_q    <= d_n;
            g_q    <= g_n;
            busy_q <= busy_n;
            done_q <= done_n;
`ifdef PISO_SERIALIZER_PARITY_EN
            par_q  <= par_n;
`endif
        end
    end

    assign accept = LOAD && ((state == IDLE) || (state == FIN));

    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        cnt_n   = cnt;
        d_n     = d_q;
        g_n     = 1'b0;
        busy_n  = busy_q;
        done_n  = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
        par_n   = par_q;
`endif
        case (state)
            IDLE, FIN: begin
                busy_n  = 1'b0;
                state_n = IDLE;
                if (accept) begin
                    state_n = SHIFT;
                    sreg_n  = P;
                    cnt_n   = CW'(WIDTH - 1);
                    d_n     = P[WIDTH-1];
                    busy_n  = 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
                    par_n   = ^P;
`endif
                end
            end
            SHIFT: begin
                if (!g_q) begin
                    g_n = 1'b1;
                end else if (cnt != '0) begin
                    // Rotate so the next bit lands on the MSB; D only moves on the edge that drops G.
                    sreg_n = {sreg[WIDTH-2:0], sreg[WIDTH-1]};
                    d_n    = sreg[WIDTH-2];
                    cnt_n  = cnt - CW'(1);
                end else begin
`ifdef PISO_SERIALIZER_PARITY_EN
                    state_n = PAR;
                    d_n     = par_q;
`else
                    state_n = FIN;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
`endif
                end
            end
`ifdef PISO_SERIALIZER_PARITY_EN
            PAR: begin
                if (!g_q) begin
                    g_n = 1'b1;
                end else begin
                    state_n = FIN;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
`endif
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign D    = d_q;
    assign G    = g_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: a word-level model predicts strobe bits, DONE cycles and BUSY per cycle.
module tb_piso_serializer;

    localparam int W    = 8;
    localparam int MAXC = 20000;
`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int L = 2 * W + 2;
    localparam bit PAR_ON = 1'b1;
`else
    localparam int L = 2 * W;
    localparam bit PAR_ON = 1'b0;
`endif

    logic         C = 1'b0;
    logic         Rn = 1'b0;
    logic         LOAD = 1'b0;
    logic [W-1:0] P = '0;
    logic         D, G, BUSY, DONE;

    piso_serializer #(.WIDTH(W)) dut (
        .C(C), .Rn(Rn), .LOAD(LOAD), .P(P),
        .D(D), .G(G), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 C = ~C;

    typedef struct {
        int cyc;
        bit is_done;
        bit val;
    } ev_t;

    ev_t exp_q[$];
    bit  busy_exp [0:MAXC-1];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;

    always @(posedge C) cyc <= cyc + 1;

    function automatic void check(bit ok, string name, int act, int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, req, cyc);
        end
    endfunction

    // Word-level model: an accepted word occupies L cycles of BUSY from its accept edge,
    // strobes bit i in cycle k+2i+1 and pulses DONE in cycle k+L.
    task automatic model_edge(bit ld, logic [W-1:0] p);
        int k;
        k = cyc + 1;
        if (ld && !busy_exp[cyc] && (k + L + 1 < MAXC)) begin
            for (int i = 0; i < W; i++)
                exp_q.push_back('{cyc: k + 2 * i + 1, is_done: 1'b0, val: p[W-1-i]});
            if (PAR_ON)
                exp_q.push_back('{cyc: k + 2 * W + 1, is_done: 1'b0, val: ^p});
            exp_q.push_back('{cyc: k + L, is_done: 1'b1, val: 1'b0});
            for (int c = k; c < k + L; c++) busy_exp[c] = 1'b1;
        end
    endtask

    task automatic cyc_drive(bit ld, logic [W-1:0] p);
        LOAD = ld;
        P    = p;
        if (Rn) model_edge(ld, p);
        @(negedge C);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            cyc_drive(1'b0, W'($urandom));
            n++;
        end
        cyc_drive(1'b0, '0);
        check(exp_q.size() == 0, "drain", exp_q.size(), 0);
    endtask

    task automatic reset_mid_cycle();
        @(posedge C);
        #2;
        Rn = 1'b0;
        exp_q.delete();
        for (int c = cyc; c < MAXC; c++) busy_exp[c] = 1'b0;
        #1;
        check(G == 1'b0, "rst_async_g", int'(G), 0);
        check(BUSY == 1'b0, "rst_async_busy", int'(BUSY), 0);
        check(DONE == 1'b0, "rst_async_done", int'(DONE), 0);
        check(D == 1'b0, "rst_async_d", int'(D), 0);
    endtask

    ev_t mon_e;
    bit  prev_g = 1'b0;
    bit  prev_d = 1'b0;

    always @(negedge C) begin
        if (!Rn) begin
            check(D == 1'b0, "rst_d", int'(D), 0);
            check(G == 1'b0, "rst_g", int'(G), 0);
            check(BUSY == 1'b0, "rst_busy", int'(BUSY), 0);
            check(DONE == 1'b0, "rst_done", int'(DONE), 0);
        end else begin
            if (G) begin
                check(!prev_g, "g_consecutive", 1, 0);
                check(D == prev_d, "d_hold_in_strobe", int'(D), int'(prev_d));
                if (exp_q.size() == 0 || exp_q[0].is_done) begin
                    check(1'b0, "unexpected_strobe", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check(mon_e.cyc == cyc, "strobe_time", cyc, mon_e.cyc);
                    check(D == mon_e.val, "strobe_bit", int'(D), int'(mon_e.val));
                end
            end
            if (DONE) begin
                if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                    check(1'b0, "unexpected_done", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check(mon_e.cyc == cyc, "done_time", cyc, mon_e.cyc);
                end
            end
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check(1'b0, "missed_event", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (cyc < MAXC)
                check(BUSY == busy_exp[cyc], "busy", int'(BUSY), int'(busy_exp[cyc]));
        end
        prev_g = G;
        prev_d = D;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int c = 0; c < MAXC; c++) busy_exp[c] = 1'b0;

        // Reset held with LOAD active and an all-ones word
        Rn   = 1'b0;
        LOAD = 1'b1;
        P    = 8'hFF;
        repeat (4) @(negedge C);
        Rn = 1'b1;
        cyc_drive(1'b0, '0);
        cyc_drive(1'b0, '0);

        // 8'hA5 word, a rejected load during it, then 8'h3C held across the DONE cycle
        cyc_drive(1'b1, 8'hA5);
        for (int i = 1; i <= 4; i++) cyc_drive(1'b0, 8'hA5);
        cyc_drive(1'b1, 8'h00);
        for (int i = 6; i <= 14; i++) cyc_drive(1'b0, 8'h00);
        for (int i = 15; i <= 17 + (PAR_ON ? 2 : 0); i++) cyc_drive(1'b1, 8'h3C);
        cyc_drive(1'b0, 8'h3C);
        drain();

        // Reset after the third strobe of 8'hA5, then 8'h81 after release
        cyc_drive(1'b1, 8'hA5);
        for (int i = 1; i <= 5; i++) cyc_drive(1'b0, 8'hA5);
        reset_mid_cycle();
        @(negedge C);
        LOAD = 1'b1;
        P    = 8'hFF;
        repeat (2) @(negedge C);
        Rn = 1'b1;
        cyc_drive(1'b1, 8'h81);
        cyc_drive(1'b0, 8'h81);
        drain();

        // Odd-parity word, exercises the parity slot when compiled in
        cyc_drive(1'b1, 8'h07);
        drain();

        // Randomized words with random gaps and random loads while busy
        for (int w = 0; w < 60; w++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) cyc_drive(1'b0, W'($urandom));
            cyc_drive(1'b1, W'($urandom));
            for (int c = 0; c < L; c++)
                cyc_drive(($urandom_range(0, 3) == 0), W'($urandom));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 SHALL have port C  input  1  clock; all state changes occur on the rising edge.
REQ-003 SHALL have port Rn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port LOAD  input  1  request to accept word P.
REQ-005 SHALL have port P  input  WIDTH  parallel word to serialize.
REQ-006 SHALL have port D  output  1  serial data bit for the downstream D latch data input.
REQ-007 SHALL have port G  output  1  gate strobe for the downstream D latch enable input.
REQ-008 SHALL have port BUSY  output  1  high while a word is being serialized.
REQ-009 SHALL have port DONE  output  1  one-cycle pulse after the last slot of a word.

Function
REQ-010 SHALL implement states IDLE, SHIFT, PAR (present only when PARITY_EN is defined) and FIN.
REQ-011 SHALL accept LOAD only at an edge where BUSY=0 (IDLE or FIN); LOAD with BUSY=1 is ignored and P is not sampled.
REQ-012 SHALL, on accept at edge k, capture P internally, set BUSY=1 and drive D=P[WIDTH-1] (MSB first) with G=0.
REQ-013 SHALL give each bit a two-cycle slot: bit i drives D from edge k+2i with G=0 (setup cycle), then G=1 from edge k+2i+1 (strobe cycle).
REQ-014 SHALL hold D stable during the whole strobe cycle and through the edge that drops G, so the latch closes on a settled value.
REQ-015 SHALL, at edge k+2*WIDTH (no parity), drive G=0, BUSY=0 and DONE=1, and enter FIN.
REQ-016 SHALL deassert DONE at the next edge and go to IDLE unless LOAD is accepted there; in that case it goes to SHIFT with the REQ-012 behaviour.
REQ-017 SHALL hold D at the last driven bit while in IDLE or FIN; G SHALL be 0 in IDLE and FIN.
REQ-018 SHALL never assert G for two consecutive cycles, and SHALL never change D in a cycle where G=1.
REQ-019 SHALL ignore P changes after the accept edge; the captured copy alone is shifted.

Reset
REQ-020 SHALL, while Rn=0 and independent of C, force state IDLE, D=0, G=0, BUSY=0, DONE=0 and clear the internal shift register.
REQ-021 SHALL abort a word in progress when Rn is asserted mid-operation, with no DONE pulse; LOAD is accepted again from the first rising edge after Rn returns to 1.

Configuration
REQ-022 SHALL compile in an even-parity slot when macro PISO_SERIALIZER_PARITY_EN is defined: after the last data bit, state PAR drives D=^P (XOR of the captured word) in one extra two-cycle slot, and DONE occurs at edge k+2*WIDTH+2.
REQ-023 SHALL, without PISO_SERIALIZER_PARITY_EN, omit the PAR state and parity logic entirely; the timing in REQ-015 applies.

Verification
REQ-024 SHALL cover reset: Rn=0 with LOAD=1 and P=8'hFF -> D=0, G=0, BUSY=0, DONE=0 throughout.
REQ-025 SHALL cover basic serialization: WIDTH=8, P=8'hA5, LOAD pulsed at edge k -> D sampled on G=1 cycles reads 1,0,1,0,0,1,0,1; DONE=1 only in the cycle after edge k+16.
REQ-026 SHALL cover busy rejection: LOAD with P=8'h00 at edge k+5 during the 8'hA5 word -> output sequence unchanged, no extra word.
REQ-027 SHALL cover back-to-back: LOAD with P=8'h3C held in the DONE cycle -> new word starts at edge k+17; G=1 slots read 0,0,1,1,1,1,0,0; no idle gap.
REQ-028 SHALL cover reset mid-word: Rn=0 after the third strobe of 8'hA5 -> G and BUSY drop at once, no DONE; a new LOAD of 8'h81 after release yields 1,0,0,0,0,0,0,1.
REQ-029 SHALL cover parity: with PISO_SERIALIZER_PARITY_EN defined and P=8'h07 -> ninth strobe carries D=1 and DONE follows at edge k+18.
